// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin arbiter that lets N_MASTERS Wishbone masters share one slave.
// A master is granted when the arbiter is idle and it raises m_cyc. It then
// keeps the bus for as long as it holds m_cyc, so bursts are never
// interleaved. Once the owner drops m_cyc, the arbiter spends one cycle idle
// before it grants the next master. A per-strobe watchdog ends a stalled
// access with a one-cycle error pulse to the owner.
//
// Parameters
//   N_MASTERS      number of masters (2..4)
//   WB_ADDR_WIDTH  address width
//   WB_DATA_WIDTH  data width; SEL is WB_DATA_WIDTH/8 bits
//   TIMEOUT        stalled-strobe cycles before m_err fires (0 = disabled)
//
// Ports
//   clk, rstn                  clock; synchronous active-low reset
//   m_cyc/m_stb/m_we           per-master control bits
//   m_adr/m_dat_w/m_sel        per-master buses, master i in slice i
//   m_cti/m_bte                per-master burst tags, master i in slice i
//   m_ack/m_err                per-master response, only owner's bit active
//   m_dat_r                    read data, shared by all masters
//   s_*                        master-side bus to the single slave
//   s_dat_r/s_ack/s_err        slave responses
//   gnt                        registered one-hot grant, zero when idle
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int N_MASTERS     = 2,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N_MASTERS-1:0]                   m_cyc,
  input  logic [N_MASTERS-1:0]                   m_stb,
  input  logic [N_MASTERS-1:0]                   m_we,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
  input  logic [N_MASTERS*3-1:0]                 m_cti,
  input  logic [N_MASTERS*2-1:0]                 m_bte,
  output logic [N_MASTERS-1:0]                   m_ack,
  output logic [N_MASTERS-1:0]                   m_err,
  output logic [WB_DATA_WIDTH-1:0]               m_dat_r,
  output logic                                   s_cyc,
  output logic                                   s_stb,
  output logic                                   s_we,
  output logic [WB_ADDR_WIDTH-1:0]               s_adr,
  output logic [WB_DATA_WIDTH-1:0]               s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
  output logic [2:0]                             s_cti,
  output logic [1:0]                             s_bte,
  input  logic [WB_DATA_WIDTH-1:0]               s_dat_r,
  input  logic                                   s_ack,
  input  logic                                   s_err,
  output logic [N_MASTERS-1:0]                   gnt
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(N_MASTERS);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   last_owner, last_owner_nxt;
  logic [IDX_W-1:0]   winner, cand;
  logic               found;
  logic [N_MASTERS-1:0] gnt_nxt;
  logic               owned;
  logic               timeout;

  // Per-master views of the packed input buses.
  logic [WB_ADDR_WIDTH-1:0] adr_a   [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0] dat_w_a [N_MASTERS];
  logic [SEL_W-1:0]         sel_a   [N_MASTERS];
  logic [2:0]               cti_a   [N_MASTERS];
  logic [1:0]               bte_a   [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign adr_a[i]   = m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign dat_w_a[i] = m_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign sel_a[i]   = m_sel[i*SEL_W +: SEL_W];
    assign cti_a[i]   = m_cti[i*3 +: 3];
    assign bte_a[i]   = m_bte[i*2 +: 2];
  end

  // Round-robin pick: first requester scanning upward from last_owner+1.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = IDX_W'((int'(last_owner) + 1 + i) % N_MASTERS);
      if (!found && m_cyc[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic for the ownership FSM.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    gnt_nxt        = gnt;
    unique case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nxt = OWNED;
          owner_nxt = winner;
          gnt_nxt   = N_MASTERS'(1) << winner;
        end
      end
      OWNED: begin
        // Dropping CYC ends the tenure; the slot goes idle for one cycle.
        if (!m_cyc[owner]) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          gnt_nxt        = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rstn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_MASTERS - 1);
      gnt        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      gnt        <= gnt_nxt;
    end
  end

  // Stall watchdog. It counts the owner's unanswered strobe cycles. When the
  // count reaches TIMEOUT, it terminates the access with an error. A
  // same-cycle ACK or ERR from the slave always takes priority.
  if (TIMEOUT > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             stalled;

    assign stalled = (state == OWNED) && m_stb[owner] && !s_ack && !s_err;
    assign timeout = stalled && (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
      if (!rstn || !stalled || timeout) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  // Reset aborts ownership at once, including in the cycle it is asserted,
  // so a late slave response never reaches a master.
  assign owned   = (state == OWNED) && rstn;
  assign m_dat_r = s_dat_r;

  // Combinational routing between the owner and the slave.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    m_ack   = '0;
    m_err   = '0;
    if (owned) begin
      s_cyc        = m_cyc[owner];
      s_stb        = m_stb[owner] && !timeout;
      s_we         = m_we[owner];
      s_adr        = adr_a[owner];
      s_dat_w      = dat_w_a[owner];
      s_sel        = sel_a[owner];
      s_cti        = cti_a[owner];
      s_bte        = bte_a[owner];
      m_ack[owner] = s_ack;
      m_err[owner] = s_err || timeout;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Directed bench for wb_rr_arbiter. It uses three masters and TIMEOUT=8.
// - A per-cycle vector table covers reset, the two-master handover, response
//   isolation and lost requests.
// - Hand-written sequences cover round-robin rotation, burst ownership, the
//   stall timeout, slave error and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [N-1:0]    m_ack, m_err;
  logic [DW-1:0]   m_dat_r;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack, s_err;
  logic [N-1:0]    gnt;

  wb_rr_arbiter #(
    .N_MASTERS    (N),
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .TIMEOUT      (TO)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_adr  (m_adr),
    .m_dat_w(m_dat_w),
    .m_sel  (m_sel),
    .m_cti  (m_cti),
    .m_bte  (m_bte),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .m_dat_r(m_dat_r),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_adr  (s_adr),
    .s_dat_w(s_dat_w),
    .s_sel  (s_sel),
    .s_cti  (s_cti),
    .s_bte  (s_bte),
    .s_dat_r(s_dat_r),
    .s_ack  (s_ack),
    .s_err  (s_err),
    .gnt    (gnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: move just past the rising edge; inputs are then applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW-1:0] adr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] dat_w_of(input int i);
    return 32'h1111_1111 * 32'(i + 1);
  endfunction

  function automatic logic [AW-1:0] exp_adr(input logic [N-1:0] g);
    case (g)
      3'b001:  return adr_of(0);
      3'b010:  return adr_of(1);
      3'b100:  return adr_of(2);
      default: return '0;
    endcase
  endfunction

  task automatic init_bus();
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = adr_of(i);
      m_dat_w[i*DW +: DW] = dat_w_of(i);
      m_sel[i*SW +: SW]   = SW'(1 << i);
      m_cti[i*3 +: 3]     = 3'b000;
      m_bte[i*2 +: 2]     = 2'b00;
    end
    m_we    = '0;
    s_dat_r = 32'h0BAD_F00D;
  endtask

  task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                       input logic ack, input logic err);
    m_cyc = cyc;
    m_stb = stb;
    s_ack = ack;
    s_err = err;
  endtask

  // Reset edge, then one quiet idle cycle.
  task automatic do_reset();
    step();
    rstn = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    step();
    rstn = 1'b1;
    settle();
  endtask

  typedef struct {
    logic         rstn;
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic         ack;
    logic         err;
    logic [N-1:0] gnt;
    logic         s_cyc;
    logic         s_stb;
    logic [N-1:0] m_ack;
    logic [N-1:0] m_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    logic [N-1:0] oh;

    // Each row holds this cycle's inputs and the outputs expected in the same
    // cycle. The grant a row produces becomes visible in the next row.
    //            rstn  cyc     stb     ack   err   gnt     scyc  sstb  m_ack   m_err
    vecs[0]  = '{1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 3'b011, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 3'b001, 3'b000};
    vecs[5]  = '{1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[6]  = '{1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[7]  = '{1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000};
    vecs[8]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[9]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[10] = '{1'b1, 3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[11] = '{1'b1, 3'b101, 3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100, 3'b100};
    vecs[12] = '{1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000};
    vecs[13] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[14] = '{1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    vecs[15] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000};

    init_bus();
    rstn = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    step();
    step();

    // Vector table: reset, two-master handover, response isolation, lost request.
    for (int k = 0; k < NV; k++) begin
      step();
      rstn = vecs[k].rstn;
      drive(vecs[k].cyc, vecs[k].stb, vecs[k].ack, vecs[k].err);
      settle();
      check($sformatf("vec%0d gnt", k),   gnt,   vecs[k].gnt);
      check($sformatf("vec%0d s_cyc", k), s_cyc, vecs[k].s_cyc);
      check($sformatf("vec%0d s_stb", k), s_stb, vecs[k].s_stb);
      check($sformatf("vec%0d m_ack", k), m_ack, vecs[k].m_ack);
      check($sformatf("vec%0d m_err", k), m_err, vecs[k].m_err);
      check($sformatf("vec%0d s_adr", k), s_adr, exp_adr(vecs[k].gnt));
    end

    // Round-robin rotation: all three keep requesting, one beat each.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      oh = 3'b001 << (r % 3);
      step();
      drive(3'b111, 3'b111, 1'b0, 1'b0);
      settle();
      check($sformatf("rr%0d idle gnt", r), gnt, 3'b000);
      step();
      drive(3'b111, 3'b111, 1'b1, 1'b0);
      settle();
      check($sformatf("rr%0d gnt", r),     gnt,     oh);
      check($sformatf("rr%0d m_ack", r),   m_ack,   oh);
      check($sformatf("rr%0d s_adr", r),   s_adr,   adr_of(r % 3));
      check($sformatf("rr%0d s_dat_w", r), s_dat_w, dat_w_of(r % 3));
      check($sformatf("rr%0d s_sel", r),   s_sel,   SW'(1 << (r % 3)));
      step();
      drive(3'b111 & ~oh, 3'b111 & ~oh, 1'b0, 1'b0);
      settle();
      check($sformatf("rr%0d drop gnt", r), gnt,   oh);
      check($sformatf("rr%0d drop cyc", r), s_cyc, 1'b0);
    end

    // Four-beat burst by master 1 while master 0 waits.
    do_reset();
    step();
    drive(3'b010, 3'b000, 1'b0, 1'b0);
    settle();
    check("burst idle gnt", gnt, 3'b000);
    m_we  = 3'b010;
    m_bte[2 +: 2] = 2'b00;
    for (int b = 0; b < 4; b++) begin
      step();
      m_adr[AW +: AW] = 32'h0000_1000 + 32'(b) * 32'h4;
      m_cti[3 +: 3]   = (b == 3) ? 3'b111 : 3'b010;
      drive(3'b011, 3'b010, 1'b1, 1'b0);
      settle();
      check($sformatf("burst%0d gnt", b),   gnt,   3'b010);
      check($sformatf("burst%0d s_cyc", b), s_cyc, 1'b1);
      check($sformatf("burst%0d s_adr", b), s_adr, 32'h0000_1000 + 32'(b) * 32'h4);
      check($sformatf("burst%0d s_cti", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
      check($sformatf("burst%0d s_bte", b), s_bte, 2'b00);
      check($sformatf("burst%0d s_we", b),  s_we,  1'b1);
      check($sformatf("burst%0d m_ack", b), m_ack, 3'b010);
    end
    step();
    drive(3'b001, 3'b000, 1'b0, 1'b0);
    settle();
    check("burst drop gnt", gnt, 3'b010);
    check("burst drop cyc", s_cyc, 1'b0);
    step();
    drive(3'b001, 3'b001, 1'b0, 1'b0);
    settle();
    check("burst gap gnt", gnt, 3'b000);
    step();
    settle();
    check("burst next gnt", gnt, 3'b001);
    check("burst next adr", s_adr, adr_of(0));
    init_bus();
    step();
    drive('0, '0, 1'b0, 1'b0);

    // Stall timeout: master 0 strobes, slave never answers.
    do_reset();
    step();
    drive(3'b011, 3'b000, 1'b0, 1'b0);
    settle();
    check("to idle gnt", gnt, 3'b000);
    for (int k = 0; k < 10; k++) begin
      step();
      drive(3'b011, 3'b001, 1'b0, 1'b0);
      settle();
      check($sformatf("to%0d gnt", k), gnt, 3'b001);
      if (k == TO) begin
        check($sformatf("to%0d m_err", k), m_err, 3'b001);
        check($sformatf("to%0d s_stb", k), s_stb, 1'b0);
      end else begin
        check($sformatf("to%0d m_err", k), m_err, 3'b000);
        check($sformatf("to%0d s_stb", k), s_stb, 1'b1);
      end
    end
    step();
    drive('0, '0, 1'b0, 1'b0);
    step();

    // Slave error on a read from master 1.
    do_reset();
    step();
    drive(3'b010, 3'b000, 1'b0, 1'b0);
    settle();
    step();
    m_we    = 3'b000;
    s_dat_r = 32'hDEAD_BEEF;
    drive(3'b010, 3'b010, 1'b0, 1'b1);
    settle();
    check("serr m_err",   m_err,   3'b010);
    check("serr m_ack",   m_ack,   3'b000);
    check("serr m_dat_r", m_dat_r, 32'hDEAD_BEEF);
    check("serr s_we",    s_we,    1'b0);
    step();
    drive('0, '0, 1'b0, 1'b0);
    s_dat_r = 32'h1234_5678;
    settle();
    check("idle m_dat_r", m_dat_r, 32'h1234_5678);
    step();

    // Reset while master 2 owns with STB high.
    do_reset();
    step();
    drive(3'b100, 3'b000, 1'b0, 1'b0);
    settle();
    step();
    drive(3'b100, 3'b100, 1'b0, 1'b0);
    settle();
    check("rst own gnt", gnt, 3'b100);
    check("rst own stb", s_stb, 1'b1);
    step();
    rstn = 1'b0;
    drive(3'b100, 3'b100, 1'b0, 1'b0);
    settle();
    check("rst cyc m_ack", m_ack, 3'b000);
    check("rst cyc m_err", m_err, 3'b000);
    step();
    rstn = 1'b1;
    drive(3'b111, 3'b111, 1'b1, 1'b0);
    settle();
    check("rst after gnt",   gnt,   3'b000);
    check("rst after s_cyc", s_cyc, 1'b0);
    check("rst after m_ack", m_ack, 3'b000);
    check("rst after m_err", m_err, 3'b000);
    step();
    drive(3'b111, 3'b111, 1'b0, 1'b0);
    settle();
    check("rst prio gnt", gnt, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

endmodule
